clock_set_controller: RTL and testbench
=======================================

// Module: clock_set_controller
// PURPOSE
//  Mode/sequencing controller for the HH:MM:SS BCD counter chain (00-59 sec, 00-59 min, 00-23 hr).
//  In RUN it chains enables tick -> sec -> min -> hr from counter carries.
//  In SET_HOUR/SET_MIN it freezes time, steps the selected counter from the INC button with
//  auto-repeat, and blinks the selected display field. Sits between debounced buttons and counters.
// PARAMETERS
//  REPEAT_DELAY   25_000_000  cycles INC must be held before auto-repeat starts (>=2)
//  REPEAT_PERIOD   5_000_000  cycles between auto-repeat steps (>=1)
//  BLINK_HALF     12_500_000  cycles per blink half-period (>=1)
// PORTS
//  clk        in   1  system clock
//  rst        in   1  synchronous, active-high reset
//  tick_1hz   in   1  one-cycle pulse, 1 Hz, from prescaler
//  btn_mode   in   1  debounced level, high = pressed
//  btn_inc    in   1  debounced level, high = pressed
//  sec_carry  in   1  seconds counter carry (combinational, en && 59)
//  min_carry  in   1  minutes counter carry (combinational, en && 59)
//  en_sec     out  1  enable to seconds counter
//  en_min     out  1  enable to minutes counter
//  en_hour    out  1  enable to hours counter
//  clr_sec    out  1  one-cycle pulse: sync clear of seconds counter to 00
//  mode       out  2  00 RUN, 01 SET_HOUR, 10 SET_MIN (11 unused)
//  blank_hr   out  1  high = blank hours digits
//  blank_min  out  1  high = blank minutes digits
// BEHAVIOUR
//  - Reset: mode=RUN, clr_sec=0, blink_phase=1 (visible), all counters/edge regs 0; outputs all 0.
//  - Edge detect: btn_x_q <= btn_x; rise = btn_x & ~btn_x_q. Press held through rst is not an edge.
//  - FSM on mode rise: RUN->SET_HOUR->SET_MIN->RUN; state updates the cycle after rise.
//  - SET_MIN->RUN: clr_sec=1 for exactly the first RUN cycle; en_sec=0 in that cycle.
//  - RUN: en_sec=tick_1hz; en_min=sec_carry; en_hour=min_carry (combinational, same cycle).
//  - SET_*: tick_1hz and carries ignored; en_sec=0. inc_step drives only the selected enable:
//    SET_HOUR en_hour=inc_step, SET_MIN en_min=inc_step. No carry ripples (min 59->00 leaves hr).
//  - inc_step: registered, high one cycle after the INC rise cycle; only in SET_* states.
//  - Auto-repeat: hold_cnt counts cycles INC high after rise; step at hold_cnt==REPEAT_DELAY,
//    then every REPEAT_PERIOD cycles while held. Release clears hold_cnt; no step on release.
//  - Mode rise and INC rise in same cycle: mode wins; INC rise discarded.
//  - Any mode change: hold_cnt cleared, repeat disarmed until INC released and re-pressed.
//  - INC in RUN: ignored, no enables, no repeat.
//  - Blink: blink_cnt runs only in SET_*; blink_phase toggles when blink_cnt==BLINK_HALF-1.
//    Entering a SET state or any inc_step: blink_cnt=0, blink_phase=1 (field visible while stepping).
//    blank_hr=(mode==SET_HOUR)&~blink_phase; blank_min=(mode==SET_MIN)&~blink_phase.
//  - Counter widths: $clog2(param+1); saturate, never wrap, while held.
//  - rst mid-set: returns to RUN next edge; counters are not touched by this block (own rst).
// STRUCTURE
//  - clock_pkg: MODE_RUN/MODE_SET_HOUR/MODE_SET_MIN localparams, 2-bit mode width.
//  - Sub-module btn_repeat (edge detect + hold/auto-repeat counter, params REPEAT_DELAY/PERIOD,
//    inputs btn, arm; output step pulse); one instance for INC. Mode FSM and blink inline.
// TESTING (bench params REPEAT_DELAY=8, REPEAT_PERIOD=3, BLINK_HALF=4)
//  1 RUN chain: tick with sec_carry=1,min_carry=1 -> en_sec,en_min,en_hour all high that cycle.
//  2 Mode cycling: 3 mode presses -> mode 01,10,00; clr_sec single pulse on return to 00, en_sec=0.
//  3 SET_MIN, tap INC once -> exactly one en_min pulse 1 cycle after rise; en_hour never high.
//  4 SET_HOUR, hold INC 20 cycles -> pulses at rise+1, hold 8, 11, 14, 17, 20; none after release.
//  5 Blink in SET_HOUR: blank_hr toggles every 4 cycles starting visible; blank_min stays 0;
//    INC step forces blank_hr=0 and restarts phase.
//  6 Mode+INC rise same cycle in SET_HOUR -> mode=10, no en_hour/en_min; rst mid-SET -> mode=00.

Source files
------------

// File: rtl/clock_pkg.sv
// Package: clock_pkg
// Shared mode encoding for the clock set controller and its display/counter
// consumers. The mode value is exported on a 2-bit port, so the enum is
// pinned to explicit encodings (11 unused).
package clock_pkg;

    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_RUN      = 2'b00,
        MODE_SET_HOUR = 2'b01,
        MODE_SET_MIN  = 2'b10
    } mode_t;

    // Mode button advances RUN -> SET_HOUR -> SET_MIN -> RUN.
    function automatic mode_t mode_advance(input mode_t m);
        case (m)
            MODE_RUN:      return MODE_SET_HOUR;
            MODE_SET_HOUR: return MODE_SET_MIN;
            default:       return MODE_RUN;
        endcase
    endfunction

endpackage

// File: rtl/clock_set_controller_btn_repeat.sv
// Module: btn_repeat
// Rising-edge detector plus hold/auto-repeat generator for one debounced
// button. A step pulse is produced one cycle after the press edge, then at
// hold count REPEAT_DELAY and every REPEAT_PERIOD cycles after that while held.
// Ports:
//   clk   in  system clock
//   rst   in  synchronous active-high reset
//   btn   in  debounced button level, high = pressed
//   arm   in  steps allowed; dropping it cancels the current press, which then
//             stays dead until the button is released and pressed again
//   step  out registered one-cycle step pulse
module btn_repeat #(
    parameter int unsigned REPEAT_DELAY  = 25_000_000,
    parameter int unsigned REPEAT_PERIOD = 5_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    input  logic arm,
    output logic step
);

    localparam int unsigned HW = $clog2(REPEAT_DELAY + 1);
    localparam int unsigned PW = $clog2(REPEAT_PERIOD + 1);
    localparam logic [HW-1:0] HOLD_MAX   = HW'(REPEAT_DELAY);
    localparam logic [PW-1:0] PER_RELOAD = PW'(REPEAT_PERIOD - 1);

    logic          btn_q;
    logic          active;
    logic [HW-1:0] hold_cnt;
    logic [PW-1:0] rep_cnt;
    logic          rise;
    logic          fire;

    // btn_q tracks the button even during reset, so a press held through
    // reset is not seen as a fresh edge afterwards.
    always_ff @(posedge clk) begin
        btn_q <= btn;
    end

    // hold_cnt equals the number of cycles since the press edge and
    // saturates at REPEAT_DELAY; rep_cnt then counts down the repeat period.
    always_comb begin
        rise = btn & ~btn_q;
        fire = 1'b0;
        if (arm && btn) begin
            if (rise)
                fire = 1'b1;
            else if (active && hold_cnt == HOLD_MAX && rep_cnt == '0)
                fire = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active   <= 1'b0;
            hold_cnt <= '0;
            rep_cnt  <= '0;
            step     <= 1'b0;
        end else begin
            step <= fire;
            if (!arm || !btn) begin
                active   <= 1'b0;
                hold_cnt <= '0;
                rep_cnt  <= '0;
            end else if (rise) begin
                active   <= 1'b1;
                hold_cnt <= HW'(1);
                rep_cnt  <= '0;
            end else if (active) begin
                if (hold_cnt < HOLD_MAX)
                    hold_cnt <= hold_cnt + 1'b1;
                else if (rep_cnt == '0)
                    rep_cnt <= PER_RELOAD;
                else
                    rep_cnt <= rep_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/clock_set_controller.sv
// Module: clock_set_controller
// Mode/sequencing controller for an HH:MM:SS BCD counter chain. In RUN the
// 1 Hz tick and counter carries are chained into counter enables. In the SET
// modes time is frozen, the INC button (with auto-repeat) steps the selected
// counter without carry ripple, and the selected display field blinks.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   tick_1hz             1 Hz one-cycle pulse from the prescaler
//   btn_mode, btn_inc    debounced button levels, high = pressed
//   sec_carry, min_carry combinational carries from the sec/min counters
//   en_sec/en_min/en_hour counter enables
//   clr_sec              one-cycle seconds clear on leaving SET_MIN
//   mode                 00 RUN, 01 SET_HOUR, 10 SET_MIN
//   blank_hr, blank_min  blank the selected digit pair (blink off phase)
module clock_set_controller
    import clock_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY  = 25_000_000,
    parameter int unsigned REPEAT_PERIOD = 5_000_000,
    parameter int unsigned BLINK_HALF    = 12_500_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_1hz,
    input  logic              btn_mode,
    input  logic              btn_inc,
    input  logic              sec_carry,
    input  logic              min_carry,
    output logic              en_sec,
    output logic              en_min,
    output logic              en_hour,
    output logic              clr_sec,
    output logic [MODE_W-1:0] mode,
    output logic              blank_hr,
    output logic              blank_min
);

    localparam int unsigned BW = $clog2(BLINK_HALF + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    mode_t         state_q;
    mode_t         state_d;
    logic          btn_mode_q;
    logic          mode_rise;
    logic          inc_arm;
    logic          inc_step;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;

    // Mode edge register follows the button through reset (no edge on a
    // press held across reset).
    always_ff @(posedge clk) begin
        btn_mode_q <= btn_mode;
    end

    assign mode_rise = btn_mode & ~btn_mode_q;

    // A mode edge in the same cycle as an INC edge wins: disarming here
    // drops the INC press until it is released and pressed again.
    assign inc_arm = (state_q != MODE_RUN) & ~mode_rise;

    btn_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_inc (
        .clk (clk),
        .rst (rst),
        .btn (btn_inc),
        .arm (inc_arm),
        .step(inc_step)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MODE_RUN;
            clr_sec <= 1'b0;
        end else begin
            state_q <= state_d;
            clr_sec <= (state_q == MODE_SET_MIN) && mode_rise;
        end
    end

    always_comb begin
        state_d   = state_q;
        en_sec    = 1'b0;
        en_min    = 1'b0;
        en_hour   = 1'b0;
        blank_hr  = 1'b0;
        blank_min = 1'b0;
        if (mode_rise)
            state_d = mode_advance(state_q);
        case (state_q)
            MODE_RUN: begin
                en_sec  = tick_1hz & ~clr_sec;
                en_min  = sec_carry;
                en_hour = min_carry;
            end
            MODE_SET_HOUR: begin
                en_hour  = inc_step;
                blank_hr = ~blink_phase;
            end
            MODE_SET_MIN: begin
                en_min    = inc_step;
                blank_min = ~blink_phase;
            end
            default: state_d = MODE_RUN;
        endcase
    end

    // Blink restarts visible on entering a SET mode and on every INC step.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (state_d != MODE_RUN && (state_d != state_q || inc_step)) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (state_q != MODE_RUN) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end else begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end
    end

    assign mode = state_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// Testbench: tb_clock_set_controller
// Directed scenarios followed by a randomized run, every cycle compared
// against a reference model that works from press times and cycle arithmetic.
module tb_clock_set_controller;

    localparam int unsigned D = 8;
    localparam int unsigned P = 3;
    localparam int unsigned H = 4;

    logic       clk = 1'b0;
    logic       rst, tick_1hz, btn_mode, btn_inc, sec_carry, min_carry;
    logic       en_sec, en_min, en_hour, clr_sec, blank_hr, blank_min;
    logic [1:0] mode;

    always #5 clk = ~clk;

    clock_set_controller #(
        .REPEAT_DELAY (D),
        .REPEAT_PERIOD(P),
        .BLINK_HALF   (H)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick_1hz (tick_1hz),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .sec_carry(sec_carry),
        .min_carry(min_carry),
        .en_sec   (en_sec),
        .en_min   (en_min),
        .en_hour  (en_hour),
        .clr_sec  (clr_sec),
        .mode     (mode),
        .blank_hr (blank_hr),
        .blank_min(blank_min)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_mode;       // 0 RUN, 1 SET_HOUR, 2 SET_MIN
    int cyc;          // current cycle index
    int blink_ref;    // cycle at which the current blink sequence started visible
    int press_k;      // cycles since the accepted INC press edge
    bit m_clr, m_step, prev_m, prev_i, press_on;
    int hr_pulses, min_pulses;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0b expected %0b (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle, compare outputs, then advance the model at the edge.
    task automatic cyc_step(input bit r, input bit t, input bit bm, input bit bi,
                            input bit sc, input bit mc);
        bit e_sec, e_min, e_hr, vis, mrise, irise, armed, fire;
        int nm;
        rst = r; tick_1hz = t; btn_mode = bm; btn_inc = bi;
        sec_carry = sc; min_carry = mc;
        #1;
        e_sec = 0; e_min = 0; e_hr = 0;
        if (m_mode == 0) begin
            e_sec = t && !m_clr;
            e_min = sc;
            e_hr  = mc;
        end else if (m_mode == 1) begin
            e_hr = m_step;
        end else begin
            e_min = m_step;
        end
        vis = (((cyc - blink_ref) / int'(H)) % 2) == 0;
        chk("en_sec", en_sec, e_sec);
        chk("en_min", en_min, e_min);
        chk("en_hour", en_hour, e_hr);
        chk("clr_sec", clr_sec, m_clr);
        chk("mode", mode, 2'(m_mode));
        chk("blank_hr", blank_hr, (m_mode == 1) && !vis);
        chk("blank_min", blank_min, (m_mode == 2) && !vis);
        if (en_hour === 1'b1) hr_pulses++;
        if (en_min === 1'b1) min_pulses++;
        @(posedge clk);
        if (r) begin
            m_mode = 0; m_clr = 0; m_step = 0; press_on = 0; press_k = 0;
            blink_ref = cyc + 1;
        end else begin
            mrise = bm && !prev_m;
            irise = bi && !prev_i;
            armed = (m_mode != 0) && !mrise;
            fire  = 0;
            if (!armed || !bi) begin
                press_on = 0;
            end else if (irise) begin
                press_on = 1; press_k = 0; fire = 1;
            end else if (press_on) begin
                press_k++;
                fire = (press_k >= int'(D)) && (((press_k - int'(D)) % int'(P)) == 0);
            end
            nm = mrise ? (m_mode + 1) % 3 : m_mode;
            m_clr = mrise && (m_mode == 2);
            if (nm != 0 && (nm != m_mode || m_step)) blink_ref = cyc + 1;
            m_step = fire;
            m_mode = nm;
        end
        prev_m = bm;
        prev_i = bi;
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc_step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic press_mode();
        cyc_step(0, 0, 1, 0, 0, 0);
        idle(2);
    endtask

    initial begin
        bit rb_m, rb_i;
        rst = 1; tick_1hz = 0; btn_mode = 0; btn_inc = 0; sec_carry = 0; min_carry = 0;
        repeat (2) @(posedge clk);
        #1;
        m_mode = 0; cyc = 0; blink_ref = 0; press_k = 0;
        m_clr = 0; m_step = 0; prev_m = 0; prev_i = 0; press_on = 0;

        // Reset state
        cyc_step(1, 0, 0, 0, 0, 0);
        cyc_step(1, 0, 0, 0, 0, 0);

        // RUN chain, then a plain tick
        cyc_step(0, 1, 0, 0, 1, 1);
        cyc_step(0, 1, 0, 0, 0, 0);
        idle(2);

        // Mode cycling with clr_sec on return to RUN (tick held high there)
        press_mode();
        press_mode();
        cyc_step(0, 0, 1, 0, 0, 0);
        cyc_step(0, 1, 0, 0, 0, 0);
        idle(2);

        // SET_MIN: single INC tap while tick/carries are asserted
        press_mode();
        press_mode();
        hr_pulses = 0; min_pulses = 0;
        cyc_step(0, 1, 0, 1, 1, 1);
        for (int i = 0; i < 8; i++) cyc_step(0, 1, 0, 0, 1, 1);
        chk_int("set_min_tap_pulses", min_pulses, 1);
        chk_int("set_min_no_hour", hr_pulses, 0);

        // Back to RUN, into SET_HOUR; hold INC through the repeat schedule
        press_mode();
        press_mode();
        hr_pulses = 0;
        for (int i = 0; i < 21; i++) cyc_step(0, 0, 0, 1, 0, 0);
        idle(10);
        chk_int("hold_repeat_pulses", hr_pulses, 6);

        // Blink in SET_HOUR, then an INC step restarting the phase
        idle(13);
        cyc_step(0, 0, 0, 1, 0, 0);
        idle(12);

        // Mode and INC edges together: mode wins, held INC stays dead
        hr_pulses = 0; min_pulses = 0;
        cyc_step(0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 14; i++) cyc_step(0, 0, 0, 1, 0, 0);
        chk_int("mode_wins_no_steps", hr_pulses + min_pulses, 0);
        idle(2);
        cyc_step(0, 0, 0, 1, 0, 0);
        idle(3);

        // Reset mid-SET, then a mode press held through reset
        cyc_step(1, 0, 0, 0, 0, 0);
        idle(2);
        press_mode();
        cyc_step(1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc_step(0, 0, 1, 0, 0, 0);
        idle(2);

        // Randomized run
        rb_m = 0; rb_i = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(39) == 0) rb_m = !rb_m;
            if ($urandom_range(14) == 0) rb_i = !rb_i;
            cyc_step($urandom_range(499) == 0, $urandom_range(5) == 0, rb_m, rb_i,
                     1'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
